// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   - state_t    : FSM state encoding (3 bits, IDLE..DIV0)
//   - DEF_WIDTH  : default operand width / iteration count
//   - DEF_CNT_W  : default step counter width (2**CNT_W > WIDTH)
//   - OP_MULT/OP_DIV : op_div encoding
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4,
        S_DIV0  = 3'd5
    } state_t;

endpackage

// File: rtl/muldiv_step_cnt.sv
// Loadable down-counter with zero flag, paces the ITER state.
// Ports:
//   clk   in  clock, rising edge
//   reset in  asynchronous active-low reset
//   clr   in  synchronous clear (abort path), highest priority
//   ld    in  load LOAD_VAL
//   dec   in  decrement (saturates at zero)
//   zero  out count is zero
module muldiv_step_cnt #(
    parameter int CNT_W    = 6,
    parameter int LOAD_VAL = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic ld,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= CNT_W'(LOAD_VAL);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the iterative multiply/divide datapath writing HI/LO.
// Takes a one-cycle start pulse from the main control FSM, walks the
// datapath through LOAD, WIDTH ITER steps, sign FIXUP and the HI/LO write,
// and returns multStop/divStop and the divide-by-zero exception pulse.
// Optional feature macro: MULDIV_EARLY_EXIT_EN (MULT leaves ITER as soon
// as early_done reports the remaining multiplier bits are zero).
// Ports:
//   clk, reset (async active-low)
//   mult_start, div_start  start pulses, honoured only in IDLE
//   flush                  synchronous abort, beats every transition
//   divisor_zero, a_sign, b_sign  sampled on the accepted start cycle
//   early_done             multiplier residual is zero
//   load, step, op_div, negate_lo, negate_hi, hilo_write  datapath controls
//   busy, multStop, divStop, div0_exc                     status to control
// All outputs are registered: each transition sets the outputs that belong
// to the state being entered.
module muldiv_seq import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic mult_start,
    input  logic div_start,
    input  logic flush,
    input  logic divisor_zero,
    input  logic a_sign,
    input  logic b_sign,
    input  logic early_done,
    output logic load,
    output logic step,
    output logic op_div,
    output logic negate_lo,
    output logic negate_hi,
    output logic hilo_write,
    output logic busy,
    output logic multStop,
    output logic divStop,
    output logic div0_exc
);

    state_t state;
    logic   a_sg, b_sg;
    logic   cnt_zero;
    logic   early;

    muldiv_step_cnt #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (WIDTH - 1)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .ld    (state == S_LOAD),
        .dec   (state == S_ITER),
        .zero  (cnt_zero)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    assign early = early_done && (op_div == OP_MULT);
`else
    logic unused_early;
    assign unused_early = early_done;
    assign early        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            a_sg       <= 1'b0;
            b_sg       <= 1'b0;
            op_div     <= OP_MULT;
            load       <= 1'b0;
            step       <= 1'b0;
            negate_lo  <= 1'b0;
            negate_hi  <= 1'b0;
            hilo_write <= 1'b0;
            busy       <= 1'b0;
            multStop   <= 1'b0;
            divStop    <= 1'b0;
            div0_exc   <= 1'b0;
        end else begin
            // single-cycle controls default low; the branch below re-asserts
            load       <= 1'b0;
            step       <= 1'b0;
            negate_lo  <= 1'b0;
            negate_hi  <= 1'b0;
            hilo_write <= 1'b0;
            multStop   <= 1'b0;
            divStop    <= 1'b0;
            div0_exc   <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // mult wins when both starts coincide
                        if (mult_start) begin
                            state  <= S_LOAD;
                            op_div <= OP_MULT;
                            a_sg   <= a_sign;
                            b_sg   <= b_sign;
                            load   <= 1'b1;
                            busy   <= 1'b1;
                        end else if (div_start) begin
                            op_div <= OP_DIV;
                            a_sg   <= a_sign;
                            b_sg   <= b_sign;
                            busy   <= 1'b1;
                            if (divisor_zero) begin
                                state    <= S_DIV0;
                                div0_exc <= 1'b1;
                                divStop  <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                                load  <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        state <= S_ITER;
                        step  <= 1'b1;
                    end
                    S_ITER: begin
                        if (cnt_zero || early) begin
                            state     <= S_FIXUP;
                            negate_lo <= a_sg ^ b_sg;
                            // remainder takes the dividend's sign
                            negate_hi <= (op_div == OP_DIV) ? a_sg : (a_sg ^ b_sg);
                        end else begin
                            step <= 1'b1;
                        end
                    end
                    S_FIXUP: begin
                        state      <= S_DONE;
                        hilo_write <= 1'b1;
                        if (op_div == OP_DIV) divStop  <= 1'b1;
                        else                  multStop <= 1'b1;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    S_DIV0: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at default WIDTH=32.
// Cycle index i counts edges after the start cycle; the state seen after
// edge i is "cycle i" (LOAD=1, ITER k = k+2, FIXUP=34, DONE=35).
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic reset;
    logic mult_start, div_start, flush, divisor_zero, a_sign, b_sign, early_done;
    logic load, step, op_div, negate_lo, negate_hi, hilo_write, busy;
    logic multStop, divStop, div0_exc;

    int nchk = 0;
    int nerr = 0;

    // per-run observations
    int load_at, load_cnt, step_cnt, step_first;
    int mstop_at, mstop_cnt, dstop_at, dstop_cnt;
    int hilo_at, hilo_cnt, div0_at, div0_cnt;
    int neg_at, neg_lo_seen, neg_hi_seen, busy_cnt, idle_at, opdiv_done;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk          (clk),
        .reset        (reset),
        .mult_start   (mult_start),
        .div_start    (div_start),
        .flush        (flush),
        .divisor_zero (divisor_zero),
        .a_sign       (a_sign),
        .b_sign       (b_sign),
        .early_done   (early_done),
        .load         (load),
        .step         (step),
        .op_div       (op_div),
        .negate_lo    (negate_lo),
        .negate_hi    (negate_hi),
        .hilo_write   (hilo_write),
        .busy         (busy),
        .multStop     (multStop),
        .divStop      (divStop),
        .div0_exc     (div0_exc)
    );

    function automatic int outs();
        return int'({load, step, op_div, negate_lo, negate_hi,
                     hilo_write, busy, multStop, divStop, div0_exc});
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse a start in the current cycle, then watch ncyc cycles. An
    // optional div_start/flush/early_done pulse is driven during cycle inj_at.
    task automatic run(input logic m, input logic d, input logic dz,
                       input logic as_, input logic bs, input int ncyc,
                       input int inj_at, input logic inj_div,
                       input logic inj_flush, input logic inj_early);
        mult_start = m; div_start = d; divisor_zero = dz;
        a_sign = as_; b_sign = bs;
        load_at = -1; load_cnt = 0; step_cnt = 0; step_first = -1;
        mstop_at = -1; mstop_cnt = 0; dstop_at = -1; dstop_cnt = 0;
        hilo_at = -1; hilo_cnt = 0; div0_at = -1; div0_cnt = 0;
        neg_at = -1; neg_lo_seen = 0; neg_hi_seen = 0; busy_cnt = 0;
        idle_at = -1; opdiv_done = -1;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                // signs flip after acceptance to show they were latched
                mult_start = 0; div_start = 0; divisor_zero = 0;
                a_sign = ~as_; b_sign = ~bs;
            end
            if (load) begin load_cnt++; if (load_at < 0) load_at = i; end
            if (step) begin step_cnt++; if (step_first < 0) step_first = i; end
            if (multStop) begin mstop_cnt++; mstop_at = i; opdiv_done = int'(op_div); end
            if (divStop) begin dstop_cnt++; dstop_at = i; opdiv_done = int'(op_div); end
            if (hilo_write) begin hilo_cnt++; hilo_at = i; end
            if (div0_exc) begin div0_cnt++; div0_at = i; end
            if (negate_lo || negate_hi) neg_at = i;
            if (negate_lo) neg_lo_seen = 1;
            if (negate_hi) neg_hi_seen = 1;
            if (busy) busy_cnt++;
            else if (idle_at < 0) idle_at = i;
            if (i == inj_at) begin
                div_start = inj_div; flush = inj_flush; early_done = inj_early;
            end else if (i == inj_at + 1) begin
                div_start = 0; flush = 0; early_done = 0;
            end
        end
        a_sign = 0; b_sign = 0;
    endtask

    initial begin
        reset = 0;
        mult_start = 0; div_start = 0; flush = 0; divisor_zero = 0;
        a_sign = 0; b_sign = 0; early_done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        reset = 1;
        @(posedge clk); #1;
        chk("idle_outs", outs(), 0);

        // unsigned mult: full latency, no fix-up
        run(1, 0, 0, 0, 0, 36, 0, 0, 0, 0);
        chk("m00_load_at", load_at, 1);
        chk("m00_step_cnt", step_cnt, 32);
        chk("m00_step_first", step_first, 2);
        chk("m00_neg", neg_lo_seen + neg_hi_seen, 0);
        chk("m00_mstop_at", mstop_at, 35);
        chk("m00_hilo_at", hilo_at, 35);
        chk("m00_dstop", dstop_cnt, 0);
        chk("m00_idle_at", idle_at, 36);

        // signed div -A/+B: quotient and remainder negated in FIXUP
        run(0, 1, 0, 1, 0, 36, 0, 0, 0, 0);
        chk("d10_neg_lo", neg_lo_seen, 1);
        chk("d10_neg_hi", neg_hi_seen, 1);
        chk("d10_neg_at", neg_at, 34);
        chk("d10_dstop_at", dstop_at, 35);
        chk("d10_div0", div0_cnt, 0);
        chk("d10_opdiv", opdiv_done, 1);
        chk("d10_mstop", mstop_cnt, 0);

        // div +A/-B: quotient negated, remainder keeps A's sign
        run(0, 1, 0, 0, 1, 36, 0, 0, 0, 0);
        chk("d01_neg_lo", neg_lo_seen, 1);
        chk("d01_neg_hi", neg_hi_seen, 0);

        // mult +A*-B: both words negated
        run(1, 0, 0, 0, 1, 36, 0, 0, 0, 0);
        chk("m01_neg_lo", neg_lo_seen, 1);
        chk("m01_neg_hi", neg_hi_seen, 1);
        chk("m01_opdiv", opdiv_done, 0);

        // divide by zero: immediate exception, no HI/LO write
        run(0, 1, 1, 0, 0, 5, 0, 0, 0, 0);
        chk("dz_div0_at", div0_at, 1);
        chk("dz_dstop_at", dstop_at, 1);
        chk("dz_hilo", hilo_cnt, 0);
        chk("dz_busy", busy_cnt, 1);
        chk("dz_load", load_cnt, 0);
        chk("dz_opdiv", int'(op_div), 1);

        // both starts together, plus a stray div_start at ITER cycle 10
        run(1, 1, 0, 0, 0, 35, 12, 1, 0, 0);
        chk("both_load_cnt", load_cnt, 1);
        chk("both_mstop_at", mstop_at, 35);
        chk("both_dstop", dstop_cnt, 0);
        chk("both_opdiv", opdiv_done, 0);

        // start during the DONE cycle is dropped
        run(0, 1, 0, 0, 0, 4, 0, 0, 0, 0);
        chk("done_start_load", load_cnt, 0);
        chk("done_start_idle", idle_at, 1);

        // flush at ITER cycle 5
        run(1, 0, 0, 1, 1, 12, 7, 0, 1, 0);
        chk("fl_idle_at", idle_at, 8);
        chk("fl_done", mstop_cnt + dstop_cnt, 0);
        chk("fl_hilo", hilo_cnt, 0);
        chk("fl_step_cnt", step_cnt, 6);
        run(1, 0, 0, 0, 0, 36, 0, 0, 0, 0);
        chk("fl_re_mstop_at", mstop_at, 35);
        chk("fl_re_step_cnt", step_cnt, 32);

        // early_done at ITER cycle 3
        run(1, 0, 0, 0, 0, 36, 5, 0, 0, 1);
`ifdef MULDIV_EARLY_EXIT_EN
        chk("ee_mstop_at", mstop_at, 7);
        chk("ee_step_cnt", step_cnt, 4);
`else
        chk("ee_mstop_at", mstop_at, 35);
        chk("ee_step_cnt", step_cnt, 32);
`endif

        // asynchronous reset at ITER cycle 20
        run(1, 0, 0, 1, 0, 22, 0, 0, 0, 0);
        chk("ar_pre_step", int'(step), 1);
        chk("ar_pre_busy", int'(busy), 1);
        #2 reset = 0;
        #1;
        chk("ar_outs", outs(), 0);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("ar_post_outs", outs(), 0);
        run(0, 1, 0, 0, 0, 36, 0, 0, 0, 0);
        chk("ar_re_dstop_at", dstop_at, 35);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
